// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, buffer entry
// layout, default buffer depth and the word used as payload for fault entries.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DROP      = 2'd2
    } fetch_state_e;

    localparam int          FIFO_DEPTH_DEFAULT = 2;
    localparam logic [31:0] NOP_WORD           = 32'h0000_0000;
    localparam int          ENTRY_W            = 65;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic        fault,
                                                input logic [31:0] pc,
                                                input logic [31:0] instr);
        fetch_entry_t e;
        e.fault = fault;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two circular FIFO of {fault, pc, instr} entries with
// a synchronous clear that takes priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [ENTRY_W-1:0]           push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [ENTRY_W-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!push && pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head is read straight from storage so decode sees only registered data.
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read, misaligned PCs turned into
// fault entries, redirects drop buffered work and any response still in flight.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_lat_q, pc_lat_d;
    logic               accept;
    logic               push;
    logic               pop;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic [CNT_W-1:0]   count;

    always_comb begin
        state_d    = state_q;
        pc_lat_d   = pc_lat_q;
        push       = 1'b0;
        push_entry = '0;
        imem_req   = 1'b0;
        imem_addr  = '0;
        // A slot is reserved before issuing, so a response can always be stored.
        pc_ready   = !reset && !flush && (state_q == IDLE) && (count < DEPTH_CNT);
        accept     = pc_valid && pc_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (pc[1:0] == 2'b00) begin
                        imem_req  = 1'b1;
                        imem_addr = pc;
                        pc_lat_d  = pc;
                        state_d   = WAIT_RESP;
                    end else begin
                        push       = 1'b1;
                        push_entry = make_entry(1'b1, pc, NOP_WORD);
                    end
                end
            end
            WAIT_RESP: begin
                if (flush) begin
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    push       = 1'b1;
                    push_entry = make_entry(1'b0, pc_lat_q, imem_rdata);
                    state_d    = IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_lat_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_lat_q <= pc_lat_d;
        end
    end

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (flush),
        .head      (head_entry),
        .count     (count)
    );

    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;
    assign instr_fault = head_entry.fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked
// against a queue-based model of the fetch buffer and outstanding read.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        flush = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault)
    );

    // Observable outputs; head fields only matter while valid, address only while requesting.
    function automatic logic [99:0] snap();
        return {pc_ready, imem_req, instr_valid,
                instr_valid ? {instr_fault, instr_pc, instr} : 65'h0,
                imem_req ? imem_addr : 32'h0};
    endfunction

    function automatic logic [99:0] want(input logic pr, input logic rq, input logic v,
                                         input logic f, input logic [31:0] ipc,
                                         input logic [31:0] ins, input logic [31:0] addr);
        return {pr, rq, v, f, ipc, ins, addr};
    endfunction

    task automatic cyc(input logic pv, input logic [31:0] p, input logic rv,
                       input logic [31:0] rd, input logic fl, input logic ir);
        @(posedge clk);
        #1;
        pc_valid    = pv;
        pc          = p;
        imem_rvalid = rv;
        imem_rdata  = rd;
        flush       = fl;
        instr_ready = ir;
        #1;
    endtask

    task automatic test_reset();
        logic [99:0] w;
        reset = 1'b1;
        cyc(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want %h", snap(), w);
        end
        cyc(1'b1, 32'h8, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        tests_run++;
        if ({instr_valid, instr_fault, instr_pc, instr, imem_req, pc_ready} !== 67'h0) begin
            tests_failed++;
            $display("FAIL reset_raw_head: got v=%b f=%b pc=%h i=%h req=%b rdy=%b want all 0",
                     instr_valid, instr_fault, instr_pc, instr, imem_req, pc_ready);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        w = want(1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL reset_release: got %h want %h", snap(), w);
        end
    endtask

    task automatic test_basic_fetch();
        logic [99:0] w;
        cyc(1'b1, 32'h0040_0000, 1'b0, 32'h0, 1'b0, 1'b1);
        w = want(1, 1, 0, 0, 0, 0, 32'h0040_0000);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL basic_issue: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 32'h8C08_0004, 1'b0, 1'b1);
        w = want(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL basic_wait: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        w = want(1, 0, 1, 0, 32'h0040_0000, 32'h8C08_0004, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL basic_deliver: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        w = want(1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL basic_one_cycle: got %h want %h", snap(), w);
        end
    endtask

    task automatic test_fill_full();
        logic [99:0] w;
        cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(1, 1, 0, 0, 0, 0, 32'h0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL fill_issue0: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h1111_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(1, 1, 1, 0, 32'h0, 32'h1111_0000, 32'h4);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL fill_issue4: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'h2222_0004, 1'b0, 1'b0);
        cyc(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(0, 0, 1, 0, 32'h0, 32'h1111_0000, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL fill_full_stall: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL fill_pop0: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        w = want(1, 0, 1, 0, 32'h4, 32'h2222_0004, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL fill_pop4: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL fill_empty: got %h want %h", snap(), w);
        end
    endtask

    task automatic test_misaligned();
        logic [99:0] w;
        cyc(1'b1, 32'h0040_0002, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL misalign_no_req: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        w = want(1, 0, 1, 1, 32'h0040_0002, 32'h0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL misalign_fault: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL misalign_popped: got %h want %h", snap(), w);
        end
    endtask

    task automatic test_flush_wait();
        logic [99:0] w;
        cyc(1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        w = want(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL flushw_flush: got %h want %h", snap(), w);
        end
        cyc(1'b1, 32'h0040_0014, 1'b0, 32'h0, 1'b0, 1'b1);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL flushw_drop_stall: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL flushw_late_resp: got %h want %h", snap(), w);
        end
        cyc(1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 1'b1);
        w = want(1, 1, 0, 0, 0, 0, 32'h0040_0020);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL flushw_refetch: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'h3C1D_1234, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        w = want(1, 0, 1, 0, 32'h0040_0020, 32'h3C1D_1234, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL flushw_deliver: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush_buffered();
        logic [99:0] w;
        cyc(1'b1, 32'h0000_0101, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0202, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(1, 0, 1, 1, 32'h0000_0101, 32'h0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL flushb_second: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        w = want(0, 0, 1, 1, 32'h0000_0101, 32'h0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL flushb_flush_pop: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL flushb_empty: got %h want %h", snap(), w);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [99:0] w;
        cyc(1'b1, 32'h0040_0040, 1'b0, 32'h0, 1'b0, 1'b0);
        w = want(1, 1, 0, 0, 0, 0, 32'h0040_0040);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL rstw_issue: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        w = want(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (snap() !== w) begin
            tests_failed++;
            $display("FAIL rstw_in_reset: got %h want %h", snap(), w);
        end
        cyc(1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({pc_ready, imem_req, instr_valid, instr_fault, instr_pc, instr} !== {1'b1, 67'h0}) begin
            tests_failed++;
            $display("FAIL rstw_release: got rdy=%b req=%b v=%b f=%b pc=%h i=%h want rdy=1 rest 0",
                     pc_ready, imem_req, instr_valid, instr_fault, instr_pc, instr);
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++;
        if ({pc_ready, imem_req, instr_valid, instr_fault, instr_pc, instr} !== {1'b1, 67'h0}) begin
            tests_failed++;
            $display("FAIL rstw_no_push: got rdy=%b req=%b v=%b f=%b pc=%h i=%h want rdy=1 rest 0",
                     pc_ready, imem_req, instr_valid, instr_fault, instr_pc, instr);
        end
    endtask

    task automatic test_random();
        logic [64:0] q[$];
        logic [64:0] head;
        logic [31:0] out_pc;
        logic [99:0] w;
        bit          outstanding;
        bit          drop;
        bit          mem_busy;
        int          mem_cnt;
        bit          e_pr, acc, e_req, e_v, deliver;
        outstanding = 0;
        drop        = 0;
        mem_busy    = 0;
        mem_cnt     = 0;
        out_pc      = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            imem_rvalid = mem_busy && (mem_cnt == 0);
            imem_rdata  = $urandom;
            pc_valid    = ($urandom_range(0, 3) != 0);
            pc          = $urandom;
            if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
            flush       = ($urandom_range(0, 11) == 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            #1;
            e_pr  = !outstanding && !flush && (q.size() < DEPTH);
            acc   = pc_valid && e_pr;
            e_req = acc && (pc[1:0] == 2'b00);
            e_v   = (q.size() != 0);
            head  = e_v ? q[0] : 65'h0;
            w = want(e_pr, e_req, e_v, head[64], head[63:32], head[31:0], e_req ? pc : 32'h0);
            tests_run++;
            if (snap() !== w) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got %h want %h", c, snap(), w);
            end
            deliver = 0;
            if (outstanding && imem_rvalid) begin
                deliver     = !drop && !flush;
                outstanding = 0;
                drop        = 0;
            end else if (outstanding && flush) begin
                drop = 1;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (e_v && instr_ready) void'(q.pop_front());
                if (acc && !e_req) q.push_back({1'b1, pc, 32'h0});
                if (deliver) q.push_back({1'b0, out_pc, imem_rdata});
            end
            if (e_req) begin
                outstanding = 1;
                out_pc      = pc;
            end
            if (imem_rvalid) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (imem_req) begin
                mem_busy = 1;
                mem_cnt  = $urandom_range(0, 2);
            end
        end
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_fill_full();
        test_misaligned();
        test_flush_wait();
        test_flush_buffered();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
